smsdac_dsm_requant: RTL and testbench



---
 rtl/smsdac_dsm_requant.sv | 161 ++++++++++++++++
 tb/tb_smsdac_dsm_requant.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smsdac_dsm_requant.sv
// smsdac_dsm_requant
//   Input stage of the segmented mismatch-shaping DAC. Accepts unsigned
//   samples over valid/ready, holds each one for OSR clocks and, every clock,
//   requantizes the held sample to a 5-bit code (0..30) with a second-order
//   error-feedback delta-sigma loop.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous active-high reset
//   en          synchronous enable, 0 forces IDLE
//   in_data     unsigned sample, full scale 2^IN_W-1
//   in_valid    in_data valid
//   in_ready    combinational, block accepts in_data this cycle
//   code        registered DAC code, 0..30
//   code_valid  registered, code is live loop output
//   underrun    registered one-cycle pulse, hold period ended without a sample
//
// States
//   ST_IDLE | loop parked, code=0, waiting for the first sample
//   ST_RUN  | loop running on the held sample, reload every OSR cycles
module smsdac_dsm_requant #(
  parameter int IN_W = 12,
  parameter int OSR  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [4:0]      code,
  output logic            code_valid,
  output logic            underrun
);

  localparam int ACC_W = IN_W + 7;
  localparam int CNT_W = (OSR > 1) ? $clog2(OSR) : 1;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t           state_q, state_d;
  logic [IN_W-1:0]  held_q, held_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IN_W-1:0]  e1_q, e1_d;
  logic [IN_W-1:0]  e2_q, e2_d;
  logic [4:0]       code_q, code_d;
  logic             code_valid_q, code_valid_d;
  logic             underrun_q, underrun_d;

  logic signed [ACC_W-1:0] held_ext;
  logic signed [ACC_W-1:0] prod30;
  logic signed [ACC_W-1:0] e1_x2;
  logic signed [ACC_W-1:0] e2_ext;
  logic signed [ACC_W-1:0] acc;
  logic signed [6:0]       q;
  logic                    last;
  logic                    accept;

  assign held_ext = {{7{1'b0}}, held_q};
  assign prod30   = (held_ext <<< 5) - (held_ext <<< 1);
  assign e1_x2    = {{6{1'b0}}, e1_q, 1'b0};
  assign e2_ext   = {{7{1'b0}}, e2_q};
  assign acc      = prod30 + e1_x2 - e2_ext;
  // Arithmetic shift by IN_W is just the top bits; the residue acc - q*2^IN_W
  // is then simply the low IN_W bits of acc.
  assign q        = acc[ACC_W-1:IN_W];

  assign last     = (cnt_q == CNT_W'(OSR - 1));
  assign in_ready = en & ((state_q == ST_IDLE) | last);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d      = state_q;
    held_d       = held_q;
    cnt_d        = cnt_q;
    e1_d         = e1_q;
    e2_d         = e2_q;
    code_d       = code_q;
    code_valid_d = code_valid_q;
    underrun_d   = 1'b0;

    if (!en) begin
      state_d      = ST_IDLE;
      cnt_d        = '0;
      e1_d         = '0;
      e2_d         = '0;
      code_d       = '0;
      code_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d        = '0;
          e1_d         = '0;
          e2_d         = '0;
          code_d       = '0;
          code_valid_d = 1'b0;
          if (accept) begin
            held_d  = in_data;
            state_d = ST_RUN;
          end
        end
        default: begin
          code_valid_d = 1'b1;
          // Out-of-range quantizer output clamps and dumps the error history
          // so the loop cannot wind up.
          if (q < 7'sd0) begin
            code_d = 5'd0;
            e1_d   = '0;
            e2_d   = '0;
          end else if (q > 7'sd30) begin
            code_d = 5'd30;
            e1_d   = '0;
            e2_d   = '0;
          end else begin
            code_d = q[4:0];
            e2_d   = e1_q;
            e1_d   = acc[IN_W-1:0];
          end

          if (last) begin
            cnt_d = '0;
            if (accept) begin
              held_d = in_data;
            end else begin
              underrun_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      held_q       <= '0;
      cnt_q        <= '0;
      e1_q         <= '0;
      e2_q         <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      held_q       <= held_d;
      cnt_q        <= cnt_d;
      e1_q         <= e1_d;
      e2_q         <= e2_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      underrun_q   <= underrun_d;
    end
  end

  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_smsdac_dsm_requant.sv
// Testbench for smsdac_dsm_requant (IN_W=12, OSR=4).
// A reference model pushes each expected code into a ring-buffer scoreboard on
// the clock edge; a monitor pops and compares on the falling edge whenever the
// DUT shows code_valid. Directed phases add hand-computed checks.
module tb_smsdac_dsm_requant;

  localparam int IN_W = 12;
  localparam int OSR  = 4;
  localparam int FS   = 1 << IN_W;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [IN_W-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      code;
  logic            code_valid;
  logic            underrun;

  always #5 clk = ~clk;

  smsdac_dsm_requant #(.IN_W(IN_W), .OSR(OSR)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .code       (code),
    .code_valid (code_valid),
    .underrun   (underrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- reference model + scoreboard producer ----------------
  bit m_idle = 1'b1;
  int m_held = 0, m_cnt = 0, m_e1 = 0, m_e2 = 0, m_code = 0;
  bit m_cv = 1'b0, m_ur = 1'b0;
  int sb_code [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int edge_cnt = 0;

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  initial begin : model
    int acc, q;
    bit rdy, acc_ok;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_idle = 1'b1; m_held = 0; m_cnt = 0; m_e1 = 0; m_e2 = 0;
        m_code = 0; m_cv = 1'b0; m_ur = 1'b0;
      end else begin
        rdy    = en && (m_idle || m_cnt == OSR - 1);
        acc_ok = in_valid && rdy;
        if (!en) begin
          m_idle = 1'b1; m_cnt = 0; m_e1 = 0; m_e2 = 0;
          m_code = 0; m_cv = 1'b0; m_ur = 1'b0;
        end else if (m_idle) begin
          m_cnt = 0; m_e1 = 0; m_e2 = 0; m_code = 0; m_cv = 1'b0; m_ur = 1'b0;
          if (acc_ok) begin
            m_held = int'(in_data);
            m_idle = 1'b0;
          end
        end else begin
          acc = m_held * 30 + 2 * m_e1 - m_e2;
          q   = (acc >= 0) ? acc / FS : -((FS - 1 - acc) / FS);
          if (q < 0) begin
            m_code = 0; m_e1 = 0; m_e2 = 0;
          end else if (q > 30) begin
            m_code = 30; m_e1 = 0; m_e2 = 0;
          end else begin
            m_code = q;
            m_e2   = m_e1;
            m_e1   = acc - q * FS;
          end
          m_cv = 1'b1;
          m_ur = (m_cnt == OSR - 1) && !acc_ok;
          if (m_cnt == OSR - 1 && acc_ok) m_held = int'(in_data);
          m_cnt = (m_cnt + 1) % OSR;
        end
        if (m_cv) begin
          sb_code[wr_ptr % 16] = m_code;
          wr_ptr++;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard consumer ----------------
  initial forever begin
    @(negedge clk);
    if (rst) begin
      rd_ptr = wr_ptr;
    end else begin
      check("code_valid", int'(code_valid), int'(m_cv));
      check("underrun", int'(underrun), int'(m_ur));
      check("in_ready", int'(in_ready), int'(en && (m_idle || m_cnt == OSR - 1)));
      if (code_valid) begin
        check("sb_pending", wr_ptr - rd_ptr, 1);
        if (wr_ptr > rd_ptr) begin
          check("code", int'(code), sb_code[rd_ptr % 16]);
          rd_ptr++;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int n_codes, sum, cmin, cmax, first;
  int acc_edges[$];
  int ur_edges[$];

  task automatic clear_stats();
    n_codes = 0; sum = 0; cmin = 99; cmax = -1; first = -1;
    acc_edges.delete();
    ur_edges.delete();
  endtask

  // Called just after a falling edge; inputs set by the caller are consumed
  // at the next rising edge, results are sampled at the following falling edge.
  task automatic cyc();
    bit pend;
    #1;
    pend = in_valid && in_ready && !rst;
    @(negedge clk);
    if (!rst && code_valid) begin
      if (n_codes == 0) first = int'(code);
      n_codes++;
      sum += int'(code);
      if (int'(code) < cmin) cmin = int'(code);
      if (int'(code) > cmax) cmax = int'(code);
    end
    if (!rst && underrun) ur_edges.push_back(edge_cnt);
    if (pend) acc_edges.push_back(edge_cnt);
    #2;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic start_phase(input int d);
    en = 1'b0;
    in_valid = 1'b0;
    cyc();
    clear_stats();
    en = 1'b1;
    in_valid = 1'b1;
    in_data = IN_W'(d);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_data = '0;
    clear_stats();
    @(negedge clk); #2;
    check("rst_code", int'(code), 0);
    check("rst_code_valid", int'(code_valid), 0);
    check("rst_underrun", int'(underrun), 0);
    rst = 1'b0;
    cyc();
    check("rdy_en0", int'(in_ready), 0);
    en = 1'b1;
    #1;
    check("rdy_en1", int'(in_ready), 1);

    // midscale: every code 15, accepts exactly every OSR cycles
    start_phase(2048);
    run(40);
    check("mid_first", first, 15);
    check("mid_min", cmin, 15);
    check("mid_max", cmax, 15);
    check("mid_ncodes", n_codes, 39);
    check("mid_naccepts", acc_edges.size(), 10);
    for (int i = 1; i < acc_edges.size(); i++)
      check("mid_acc_interval", acc_edges[i] - acc_edges[i-1], OSR);

    // zero scale
    start_phase(0);
    run(20);
    check("zero_max", cmax, 0);
    check("zero_ncodes", n_codes, 19);

    // full scale: 29 first, then alternates with the clamp at 30
    start_phase(4095);
    run(1025);
    check("full_first", first, 29);
    check("full_min", cmin, 29);
    check("full_max", cmax, 30);
    check("full_ncodes", n_codes, 1024);

    // fractional value 1365/4096*30 = 9.9976
    start_phase(1365);
    run(4097);
    check("frac_ncodes", n_codes, 4096);
    check_range("frac_min", cmin, 8, 12);
    check_range("frac_max", cmax, 8, 12);
    check_range("frac_sum_x1e4", sum * 10000, (99976 - 100) * 4096, (99976 + 100) * 4096);

    // underrun: one sample then starve the input
    start_phase(1365);
    cyc();
    check("ur_first_accept", acc_edges.size(), 1);
    k = (acc_edges.size() > 0) ? acc_edges[0] : 0;
    in_valid = 1'b0;
    run(13);
    check("ur_count", ur_edges.size(), 3);
    for (int i = 0; i < ur_edges.size(); i++)
      check("ur_edge", ur_edges[i] - k, 4 * (i + 1));
    check_range("ur_code_min", cmin, 8, 12);
    check_range("ur_code_max", cmax, 8, 12);
    in_valid = 1'b1;
    in_data = IN_W'(2048);
    #1;
    check("ur_midperiod_rdy", int'(in_ready), 0);
    run(3);
    check("ur_reaccept_count", acc_edges.size(), 2);
    if (acc_edges.size() == 2) check("ur_reaccept_edge", acc_edges[1] - k, 16);
    check("ur_count_after", ur_edges.size(), 3);

    // enable drop during RUN
    en = 1'b0;
    #1;
    check("endrop_rdy", int'(in_ready), 0);
    cyc();
    check("endrop_code", int'(code), 0);
    check("endrop_cv", int'(code_valid), 0);
    en = 1'b1;
    cyc();
    check("reen_cv_edge1", int'(code_valid), 0);
    cyc();
    check("reen_cv_edge2", int'(code_valid), 1);
    check("reen_code", int'(code), 15);

    // asynchronous reset mid-RUN with held=1365, cnt=2
    start_phase(1365);
    run(3);
    check("prerst_cv", int'(code_valid), 1);
    rst = 1'b1;
    #1;
    check("arst_code", int'(code), 0);
    check("arst_cv", int'(code_valid), 0);
    check("arst_underrun", int'(underrun), 0);
    cyc();
    in_valid = 1'b0;
    rst = 1'b0;
    cyc();
    check("postrst_rdy_en1", int'(in_ready), 1);
    en = 1'b0;
    #1;
    check("postrst_rdy_en0", int'(in_ready), 0);
    cyc();

    check("sb_drain", wr_ptr - rd_ptr, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
